// File: rtl/xbus_master_arbiter.sv
// xbus_master_arbiter: round-robin sharing of one xbus master port among C_NUM_MASTERS requesters,
// one transaction per grant, with a watchdog that revokes grants that are never used.
module xbus_master_arbiter #(
  parameter int C_NUM_MASTERS = 2,
  parameter int C_GNT_TIMEOUT = 16
) (
  input  logic                        Bus2IP_Mst_Clk,
  input  logic                        Bus2IP_Mst_Resetn,
  input  logic [C_NUM_MASTERS-1:0]    ma_req,
  output logic [C_NUM_MASTERS-1:0]    xbm_gnt,
  input  logic [C_NUM_MASTERS-1:0]    ma_select,
  input  logic [32*C_NUM_MASTERS-1:0] ma_addr,
  input  logic [32*C_NUM_MASTERS-1:0] ma_data,
  input  logic [C_NUM_MASTERS-1:0]    ma_rnw,
  input  logic [4*C_NUM_MASTERS-1:0]  ma_be,
  output logic [C_NUM_MASTERS-1:0]    xbm_ack,
  output logic [31:0]                 xbm_data,
  output logic                        arb_req,
  input  logic                        arb_gnt,
  output logic                        arb_select,
  output logic [31:0]                 arb_addr,
  output logic [31:0]                 arb_data,
  output logic                        arb_rnw,
  output logic [3:0]                  arb_be,
  input  logic                        arb_ack,
  input  logic [31:0]                 arb_rdata,
  output logic                        arb_timeout
);
  localparam int N  = C_NUM_MASTERS;
  localparam int OW = $clog2(N);
  localparam int WW = $clog2(C_GNT_TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;
  state_t state, state_n;
  logic [OW-1:0] owner, owner_n, last, last_n, win, idx;
  logic [WW-1:0] wd, wd_n;
  logic [N-1:0] owner_oh;
  logic [31:0] rdata_q;
  logic found, granted, busy, own_sel, own_req, wd_hit;
  assign owner_oh = N'(1) << owner;
  assign own_sel  = ma_select[owner];
  assign own_req  = ma_req[owner];
  assign wd_hit   = wd == WW'(C_GNT_TIMEOUT - 1);
  assign granted  = state == GRANT || state == BUSY;
  assign busy     = state == BUSY;
  // first requester scanning upward from the one after the last served
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = OW'((int'(last) + i) % N);
      if (!found && ma_req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = last;
    wd_n = wd;
    arb_timeout = 1'b0;
    case (state)
      IDLE: if (found) begin
        owner_n = win;
        wd_n = '0;
        state_n = GRANT;
      end
      GRANT: if (own_sel && arb_gnt) state_n = BUSY;
      else if (!own_req) begin
        last_n = owner;
        state_n = RELEASE;
      end else if (wd_hit) begin
        arb_timeout = 1'b1;
        last_n = owner;
        state_n = RELEASE;
      end else wd_n = wd + WW'(1);
      BUSY: if (arb_ack) begin
        last_n = owner;
        state_n = RELEASE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Bus2IP_Mst_Clk or negedge Bus2IP_Mst_Resetn)
    if (!Bus2IP_Mst_Resetn) begin
      state <= IDLE;
      owner <= '0;
      last <= OW'(N - 1);
      wd <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      wd <= wd_n;
      if (busy && arb_ack) rdata_q <= arb_rdata;
    end
  assign xbm_gnt    = granted ? owner_oh : '0;
  assign arb_req    = granted;
  assign arb_select = busy & own_sel;
  assign arb_addr   = busy ? ma_addr[int'(owner)*32 +: 32] : '0;
  assign arb_data   = busy ? ma_data[int'(owner)*32 +: 32] : '0;
  assign arb_rnw    = busy & ma_rnw[owner];
  assign arb_be     = busy ? ma_be[int'(owner)*4 +: 4] : '0;
  assign xbm_ack    = (busy && arb_ack) ? owner_oh : '0;
  assign xbm_data   = rdata_q;
endmodule
